// File: rtl/lsu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_sequencer
// Function : load/store sequencer that splits word-crossing accesses into two
//            aligned memory accesses and byte-selects/extends load results
// Revision : 1.0
// ============================================================================
module lsu_mem_sequencer #(
  parameter int DW       = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ0 = 3'd1,
    S_RD0  = 3'd2,
    S_REQ1 = 3'd3,
    S_RD1  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic          r_err;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] sz, input logic [1:0] off);
    logic [2:0] nbytes;
    nbytes = (sz == 2'b00) ? 3'd1 : (sz == 2'b01) ? 3'd2 : 3'd4;
    return ({1'b0, off} + nbytes) > 3'd4;
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  logic w_accept;
  logic w_req_err;
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_req_err = !funct3_legal(req_we, req_funct3) ||
                     (crosses_word(req_funct3[1:0], req_addr[1:0]) && (SPLIT_EN == 1'b0));

  logic [1:0]      w_off;
  logic            w_span;
  logic [7:0]      w_be_wide;
  logic [2*DW-1:0] w_wd_wide;
  logic [DW-1:0]   w_word0;
  logic [DW-1:0]   w_word1;
  logic [DW-1:0]   w_merged;
  logic [DW-1:0]   w_ext;

  // Upper halves of the widened lane/data vectors spill into the second word
  assign w_off     = r_addr[1:0];
  assign w_span    = crosses_word(r_funct3[1:0], w_off);
  assign w_be_wide = {4'b0000, size_mask(r_funct3[1:0])} << w_off;
  assign w_wd_wide = {{DW{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_word0   = {r_addr[DW-1:2], 2'b00};
  assign w_word1   = w_word0 + DW'(4);
  assign w_merged  = DW'({r_buf1, r_buf0} >> {w_off, 3'b000});

  always_comb begin
    w_ext = w_merged;
    case (r_funct3)
      3'b000:  w_ext = {{(DW-8){w_merged[7]}}, w_merged[7:0]};
      3'b001:  w_ext = {{(DW-16){w_merged[15]}}, w_merged[15:0]};
      3'b100:  w_ext = {{(DW-8){1'b0}}, w_merged[7:0]};
      3'b101:  w_ext = {{(DW-16){1'b0}}, w_merged[15:0]};
      default: w_ext = w_merged;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf0   <= '0;
      r_buf1   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
        r_buf0   <= '0;
        r_buf1   <= '0;
      end
      if ((r_state == S_RD0) && mem_rvalid) r_buf0 <= mem_rdata;
      if ((r_state == S_RD1) && mem_rvalid) r_buf1 <= mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = 4'b0000;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_err ? S_RESP : S_REQ0;
      end
      S_REQ0: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_word0;
        mem_be    = w_be_wide[3:0];
        mem_wdata = w_wd_wide[DW-1:0];
        if (mem_gnt) begin
          if (!r_we)       w_state_nxt = S_RD0;
          else if (w_span) w_state_nxt = S_REQ1;
          else             w_state_nxt = S_RESP;
        end
      end
      S_RD0: begin
        if (mem_rvalid) w_state_nxt = w_span ? S_REQ1 : S_RESP;
      end
      S_REQ1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_word1;
        mem_be    = w_be_wide[7:4];
        mem_wdata = w_wd_wide[2*DW-1:DW];
        if (mem_gnt) w_state_nxt = r_we ? S_RESP : S_RD1;
      end
      S_RD1: begin
        if (mem_rvalid) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_err     = r_err;
        rsp_rdata   = (r_we || r_err) ? '0 : w_ext;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_sequencer
// Function : directed and randomized checks of lsu_mem_sequencer against a
//            byte-level memory model
// Revision : 1.0
// ============================================================================
module tb_lsu_mem_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_valid2, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        d2_gnt, d2_rvalid;
  logic [31:0] d2_mrdata;
  logic        d2_req_ready, d2_rsp_valid, d2_rsp_err, d2_mem_req, d2_mem_we;
  logic [31:0] d2_rsp_rdata, d2_mem_addr, d2_mem_wdata;
  logic [3:0]  d2_mem_be;

  lsu_mem_sequencer #(.DW(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_mem_sequencer #(.DW(32), .SPLIT_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(d2_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata), .rsp_err(d2_rsp_err),
    .mem_req(d2_mem_req), .mem_gnt(d2_gnt), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr),
    .mem_be(d2_mem_be), .mem_wdata(d2_mem_wdata), .mem_rvalid(d2_rvalid), .mem_rdata(d2_mrdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];

  int          no;
  logic [31:0] oaddr [4];
  logic [31:0] odata [4];
  logic [3:0]  obe   [4];
  logic        owe   [4];
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] bemask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk_reset_values();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_be",    32'(mem_be),    32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
  endtask

  // One complete transaction: the bench plays the memory and compares against
  // a byte-by-byte model of which words/lanes the access must touch.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gdly, input bit noise);
    int size, n, exp_cycles, waitc, lane;
    logic exp_err, pend, seen, have_first, f_we;
    logic [31:0] eaddr [2];
    logic [31:0] edata [2];
    logic [3:0]  ebe   [2];
    logic [31:0] ldv, exp_rd, a, w, tmp, paddr, f_addr, f_data;
    logic [3:0]  f_be;

    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    exp_err = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 0; ldv = 32'd0;
    for (int i = 0; i < size; i++) begin
      a    = addr + 32'(i);
      w    = {a[31:2], 2'b00};
      lane = int'(a[1:0]);
      if (n == 0 || eaddr[n-1] != w) begin
        eaddr[n] = w; ebe[n] = 4'b0000; edata[n] = 32'd0; n++;
      end
      ebe[n-1][lane]         = 1'b1;
      edata[n-1][8*lane +: 8] = wd[8*i +: 8];
      tmp                    = rd_word(w);
      ldv[8*i +: 8]          = tmp[8*lane +: 8];
    end
    if (exp_err) n = 0;
    case (f3)
      3'd0:    exp_rd = {{24{ldv[7]}}, ldv[7:0]};
      3'd1:    exp_rd = {{16{ldv[15]}}, ldv[15:0]};
      3'd4:    exp_rd = {24'd0, ldv[7:0]};
      3'd5:    exp_rd = {16'd0, ldv[15:0]};
      default: exp_rd = ldv;
    endcase
    exp_cycles = exp_err ? 1 : (we ? n * (1 + gdly) + 1 : n * (2 + gdly) + 1);

    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    no = 0; got_cycles = 1; waitc = 0; pend = 1'b0; seen = 1'b0; have_first = 1'b0;
    f_we = 1'b0; f_addr = 32'd0; f_data = 32'd0; f_be = 4'd0; paddr = 32'd0;
    while (got_cycles <= 60) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      chk("busy_ready", 32'(req_ready), 32'd0);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = rd_word(paddr); pend = 1'b0;
      end else if (noise) begin
        mem_rvalid = 1'($urandom_range(0, 1));
      end
      if (mem_req) begin
        if (have_first) begin
          chk("hold_addr",  mem_addr,       f_addr);
          chk("hold_be",    32'(mem_be),    32'(f_be));
          chk("hold_we",    32'(mem_we),    32'(f_we));
          chk("hold_wdata", mem_wdata,      f_data);
        end else begin
          have_first = 1'b1;
          f_addr = mem_addr; f_be = mem_be; f_we = mem_we; f_data = mem_wdata;
        end
        if (waitc < gdly) begin
          waitc++;
        end else begin
          mem_gnt = 1'b1;
          if (no < 4) begin
            oaddr[no] = mem_addr; obe[no] = mem_be; owe[no] = mem_we; odata[no] = mem_wdata;
          end
          no++;
          if (mem_we) begin
            tmp = rd_word(mem_addr);
            for (int k = 0; k < 4; k++)
              if (mem_be[k]) tmp[8*k +: 8] = mem_wdata[8*k +: 8];
            mem[mem_addr] = tmp;
          end else begin
            pend = 1'b1; paddr = mem_addr;
          end
          waitc = 0; have_first = 1'b0;
        end
      end else if (noise) begin
        mem_gnt = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      got_cycles++;
    end

    chk("rsp_seen", 32'(seen), 32'd1);
    got_err = rsp_err; got_rdata = rsp_rdata;
    if (seen) begin
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("latency", 32'(got_cycles), 32'(exp_cycles));
      chk("n_access", 32'(no), 32'(n));
      for (int k = 0; k < n && k < no && k < 4; k++) begin
        chk("acc_addr", oaddr[k], eaddr[k]);
        chk("acc_be",   32'(obe[k]), 32'(ebe[k]));
        chk("acc_we",   32'(owe[k]), 32'(we));
        if (we) chk("acc_wdata", odata[k] & bemask(ebe[k]), edata[k] & bemask(ebe[k]));
      end
      if (!exp_err) chk("rsp_rdata", rsp_rdata, we ? 32'd0 : exp_rd);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("ready_after",   32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    logic [2:0]  legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    d2_gnt = 1'b1; d2_rvalid = 1'b1; d2_mrdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_values();

    // LB from the top byte of a word, sign-extended
    mem[32'h100] = 32'h80AA_BBCC;
    run_txn(1'b0, 3'b000, 32'h103, 32'd0, 0, 1'b0);
    chk("lb_be", 32'(obe[0]), 32'h8);
    chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
    chk("lb_cycles", 32'(got_cycles), 32'd3);

    mem[32'h100] = 32'h1234_5678;
    run_txn(1'b0, 3'b101, 32'h102, 32'd0, 0, 1'b0);
    chk("lhu_be", 32'(obe[0]), 32'hC);
    chk("lhu_rdata", got_rdata, 32'h0000_1234);

    mem[32'h100] = 32'h4433_2211; mem[32'h104] = 32'h8877_6655;
    run_txn(1'b0, 3'b010, 32'h101, 32'd0, 0, 1'b0);
    chk("lw_split_be0", 32'(obe[0]), 32'hE);
    chk("lw_split_be1", 32'(obe[1]), 32'h1);
    chk("lw_split_rdata", got_rdata, 32'h5544_3322);
    chk("lw_split_cycles", 32'(got_cycles), 32'd5);

    run_txn(1'b1, 3'b010, 32'h0FE, 32'hDEAD_BEEF, 0, 1'b0);
    chk("sw_split_addr0", oaddr[0], 32'h0FC);
    chk("sw_split_be0", 32'(obe[0]), 32'hC);
    chk("sw_split_data0", 32'(odata[0][31:16]), 32'hBEEF);
    chk("sw_split_addr1", oaddr[1], 32'h100);
    chk("sw_split_be1", 32'(obe[1]), 32'h3);
    chk("sw_split_data1", 32'(odata[1][15:0]), 32'hDEAD);
    chk("sw_split_cycles", 32'(got_cycles), 32'd3);

    run_txn(1'b0, 3'b011, 32'h100, 32'd0, 0, 1'b0);
    chk("ill_load_err", 32'(got_err), 32'd1);
    run_txn(1'b1, 3'b100, 32'h100, 32'd0, 0, 1'b0);
    chk("ill_store_err", 32'(got_err), 32'd1);

    // Second word wraps around the top of the address space
    run_txn(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 0, 1'b0);

    // Non-splitting instance flags a crossing halfword without touching memory
    req_valid2 = 1'b1; req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h3;
    chk("d2_ready", 32'(d2_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    chk("d2_rsp_valid", 32'(d2_rsp_valid), 32'd1);
    chk("d2_rsp_err", 32'(d2_rsp_err), 32'd1);
    chk("d2_no_mem_req", 32'(d2_mem_req), 32'd0);
    @(posedge clk); #1;
    chk("d2_idle", 32'(d2_req_ready), 32'd1);

    // Slow grant: request must hold steady while waiting
    run_txn(1'b0, 3'b010, 32'h104, 32'd0, 3, 1'b0);
    chk("slow_lw_cycles", 32'(got_cycles), 32'd6);
    run_txn(1'b1, 3'b001, 32'h10B, 32'h0000_A55A, 3, 1'b0);

    // Reset during RD0 drops the access silently
    mem[32'h200] = 32'h0BAD_F00D;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_seq_req0", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rst_seq_rd0", 32'(mem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    #2;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    for (int t = 0; t < 150; t++) begin
      rwe = 1'($urandom);
      rf3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      if (rwe && $urandom_range(0, 3) != 0) rf3 = 3'($urandom_range(0, 2));
      raddr = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                           : (32'h100 + 32'($urandom_range(0, 63)));
      run_txn(rwe, rf3, raddr, $urandom, $urandom_range(0, 2), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
- Multi-cycle load/store sequencer between the core's memory stage and the word-addressed data memory port.
- Accepts one load or store per request; generates aligned word accesses with byte enables.
- Splits misaligned halfword/word accesses into two aligned accesses.
- Merges read data, then byte-selects and sign/zero-extends load results (LB/LH/LW/LBU/LHU semantics) before returning them to writeback.

Parameters:
- DW, 32, data/address width (equals `DataBusBits`)
- SPLIT_EN, 1, 1 = split misaligned accesses; 0 = flag misaligned as error without memory access

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  DW  byte address
- req_wdata  in  DW  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DW  extended load result (0 for stores)
- rsp_err  out  1  illegal funct3, or misaligned with SPLIT_EN=0; valid with rsp_valid
- mem_req  out  1  memory access request
- mem_gnt  in  1  memory accepts request this cycle
- mem_we  out  1  write strobe
- mem_addr  out  DW  word-aligned address ([1:0]=00)
- mem_be  out  4  byte enables
- mem_wdata  out  DW  shifted store data
- mem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- mem_rdata  in  DW  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. Reset mid-access drops the transaction silently; no rsp_valid is issued.
- States: IDLE, REQ0, RD0, REQ1, RD1, RESP.
- IDLE: req_ready=1. On accept, latch we/funct3/addr/wdata.
  - Size from funct3[1:0]: 1, 2 or 4 bytes.
  - off = addr[1:0]; span = off + size > 4.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010 → RESP with err=1.
  - span with SPLIT_EN=0 → RESP with err=1.
  - Otherwise → REQ0.
- REQ0: mem_req=1, mem_addr={addr[DW-1:2],2'b00}, mem_be=(size mask)<<off truncated to 4 bits, mem_wdata=wdata<<(8*off). Hold all mem_* stable until mem_gnt.
  - On gnt, load → RD0.
  - On gnt, store → REQ1 if span, else RESP.
- RD0: wait for mem_rvalid; capture mem_rdata into buf0. Next REQ1 if span, else RESP.
- REQ1: mem_addr = first word + 4 (wraps modulo 2^DW), mem_be = (size mask)>>(4-off), mem_wdata = wdata>>(8*(4-off)).
  - On gnt, load → RD1.
  - On gnt, store → RESP.
- RD1: on rvalid capture buf1 → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. req_ready=0 in every state except IDLE.
  - Load result: merged = {buf1,buf0} >> (8*off), low bits taken.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Latency (zero-wait memory: gnt same cycle as req, rvalid next cycle):
  - Aligned load: accept→rsp_valid = 3 cycles.
  - Aligned store: 2 cycles.
  - Split load: 5 cycles.
  - Split store: 3 cycles.
  - Error: 1 cycle.
- mem_rvalid outside RD0/RD1 is ignored. mem_gnt while mem_req=0 is ignored.
- The next request may be accepted in the cycle after rsp_valid.

Test Plan:
- LB addr 0x103, mem word 0x80AA_BBCC, gnt immediate → single access be=1000, rsp_rdata=0xFFFF_FF80, rsp_err=0, 3 cycles.
- LHU addr 0x102, word 0x1234_5678 → be=1100, rsp_rdata=0x0000_1234.
- LW addr 0x101, words @0x100=0x4433_2211, @0x104=0x8877_6655 → two accesses (be 1110 then 0001), rsp_rdata=0x5544_3322, 5 cycles.
- SW 0xDEAD_BEEF at 0x0FE → access 0x0FC be=1100 wdata=0xBEEF_xxxx, then 0x100 be=0011 wdata=0xxxxx_DEAD; one rsp_valid.
- Load funct3=011 → no mem_req, rsp_valid with rsp_err=1 next cycle; with SPLIT_EN=0, LH addr 0x3 → rsp_err=1.
- mem_gnt delayed 3 cycles with mem_addr/be held stable; rst_n pulsed low during RD0 → all outputs at reset values, req_ready=1, no rsp_valid.
